wb_axi_drain: RTL and testbench

AXI4 write initiator that drains the write buffer. It takes the head entry the buffer presents (a 16-byte-aligned address and a 128-bit line), issues one 4-beat INCR burst of 32-bit beats on the AXI write channels, and waits for the write response. It then pulses `done_o`, which is wired to the buffer's pop/valid input so the head entry retires. It sits between the write buffer and the AXI interconnect arbiter.

---
 rtl/wb_axi_pkg.sv | 20 ++
 rtl/wb_axi_drain.sv | 114 +++++++++++
 tb/tb_wb_axi_drain.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_axi_pkg.sv
// Shared constants and FSM state type for the write-buffer AXI drain path.
package wb_axi_pkg;

    localparam int LINE_W = 128;
    localparam int BEAT_W = 32;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [7:0] AXI_LEN_LINE   = 8'd3;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        RESP,
        DONE
    } drain_state_t;

endpackage

// File: rtl/wb_axi_drain.sv
// Drains one write-buffer line as a 4-beat AXI4 INCR burst, then pops it.
// Optional sticky error capture: define WB_AXI_DRAIN_ERR_EN.
module wb_axi_drain
    import wb_axi_pkg::*;
#(
    parameter logic [3:0] AXI_ID = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wen_i,
    input  logic [31:0]       waddr_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic              done_o,
    output logic              busy_o,
`ifdef WB_AXI_DRAIN_ERR_EN
    output logic              err_o,
    output logic [31:0]       err_addr_o,
`endif
    output logic [3:0]        awid,
    output logic [31:0]       awaddr,
    output logic [7:0]        awlen,
    output logic [2:0]        awsize,
    output logic [1:0]        awburst,
    output logic              awvalid,
    input  logic              awready,
    output logic [BEAT_W-1:0] wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    drain_state_t      state;
    logic [31:0]       addr_q;
    logic [LINE_W-1:0] line_q;
    logic [1:0]        beat;

    assign awid    = AXI_ID;
    assign awlen   = AXI_LEN_LINE;
    assign awsize  = AXI_SIZE_4B;
    assign awburst = AXI_BURST_INCR;

    // Payloads come straight from the latch registers, so they stay stable under stall.
    assign awvalid = (state == ADDR);
    assign awaddr  = addr_q;
    assign wvalid  = (state == DATA);
    assign wstrb   = wvalid ? 4'hF : 4'h0;
    assign wlast   = wvalid && (beat == 2'd3);
    assign wdata   = line_q[{beat, 5'b0} +: BEAT_W];
    assign bready  = (state == RESP);
    assign done_o  = (state == DONE);
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            line_q <= '0;
            beat   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (wen_i) begin
                        addr_q <= {waddr_i[31:4], 4'b0};
                        line_q <= wdata_i;
                        beat   <= '0;
                        state  <= ADDR;
                    end
                end
                ADDR: begin
                    if (awready) state <= DATA;
                end
                DATA: begin
                    if (wready) begin
                        beat <= beat + 2'd1;
                        if (wlast) state <= RESP;
                    end
                end
                RESP: begin
                    if (bvalid) state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_AXI_DRAIN_ERR_EN
    logic unused_in;
    assign unused_in = ^waddr_i[3:0];

    // Only the first failing burst is recorded; later errors are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else if (bready && bvalid && (bresp != AXI_RESP_OKAY) && !err_o) begin
            err_o      <= 1'b1;
            err_addr_o <= addr_q;
        end
    end
`else
    logic unused_in;
    assign unused_in = ^{waddr_i[3:0], bresp};
`endif

endmodule

// File: tb/tb_wb_axi_drain.sv
// Self-checking bench for wb_axi_drain: cycle table, directed corners, random runs.
// Build with WB_AXI_DRAIN_ERR_EN defined to also cover error capture.
module tb_wb_axi_drain;
    import wb_axi_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         wen_i;
    logic [31:0]  waddr_i;
    logic [127:0] wdata_i;
    logic         done_o;
    logic         busy_o;
    logic [3:0]   awid;
    logic [31:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
`ifdef WB_AXI_DRAIN_ERR_EN
    logic         err_o;
    logic [31:0]  err_addr_o;
`endif

    wb_axi_drain #(.AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst), .wen_i(wen_i), .waddr_i(waddr_i),
        .wdata_i(wdata_i), .done_o(done_o), .busy_o(busy_o),
`ifdef WB_AXI_DRAIN_ERR_EN
        .err_o(err_o), .err_addr_o(err_addr_o),
`endif
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Cycle-by-cycle vector table
    typedef struct {
        logic         rst;
        logic         wen;
        logic [31:0]  addr;
        logic [127:0] data;
        logic         awr;
        logic         wr;
        logic         bv;
        logic         awv;
        logic         wv;
        logic         wl;
        logic         br;
        logic         dn;
        logic         busy;
        logic         pay;
        logic [31:0]  awaddr;
        logic [31:0]  wdat;
        logic [3:0]   wstrb;
    } vec_t;

    localparam int NV = 10;
    vec_t tbl[NV];

    // Random/directed run model state
    localparam int AL = 600;
    localparam int CAP = 500;
    logic         awr_a[AL];
    logic         wr_a[AL];
    logic         bv_a[AL];
    logic [31:0]  h_addr[8];
    logic [127:0] h_data[8];
    logic [1:0]   h_resp[8];
    logic         e_awv[AL];
    logic         e_wv[AL];
    logic         e_wl[AL];
    logic         e_br[AL];
    logic         e_dn[AL];
    logic         e_busy[AL];
    logic [31:0]  e_awaddr[AL];
    logic [31:0]  e_wd[AL];
    int           aw_cyc[8];
    int           done_cyc;
    int           got_aw;
    int           got_w;
    int           got_dn;

    // Handshake-level model: each phase ends at the first cycle its ready/valid is high.
    task automatic build_model(input int n, output int endr);
        int s;
        int a;
        int w;
        int b;
        for (int r = 0; r < AL; r++) begin
            e_awv[r] = 0; e_wv[r] = 0; e_wl[r] = 0;
            e_br[r] = 0; e_dn[r] = 0; e_busy[r] = 0;
            e_awaddr[r] = '0; e_wd[r] = '0;
        end
        s = 0;
        for (int e = 0; e < n; e++) begin
            a = s + 1;
            while (a < CAP && !awr_a[a]) a++;
            for (int r = s + 1; r <= a; r++) begin
                e_awv[r] = 1;
                e_awaddr[r] = {h_addr[e][31:4], 4'h0};
            end
            w = a;
            for (int k = 0; k < 4; k++) begin
                int st;
                st = w + 1;
                w = st;
                while (w < CAP && !wr_a[w]) w++;
                for (int r = st; r <= w; r++) begin
                    e_wv[r] = 1;
                    e_wd[r] = h_data[e][32*k +: 32];
                    e_wl[r] = (k == 3);
                end
            end
            b = w + 1;
            while (b < CAP && !bv_a[b]) b++;
            for (int r = w + 1; r <= b; r++) e_br[r] = 1;
            e_dn[b+1] = 1;
            for (int r = s + 1; r <= b + 1; r++) e_busy[r] = 1;
            s = b + 2;
        end
        endr = s + 1;
    endtask

    // Runs n heads through the DUT starting next cycle; DUT must be idle on entry.
    task automatic run(input int n);
        int endr;
        int hidx;
        build_model(n, endr);
        hidx = 0;
        got_aw = 0;
        got_w = 0;
        done_cyc = -1;
        for (int r = 0; r < endr; r++) begin
            @(posedge clk); #1;
            wen_i   = (hidx < n);
            awready = awr_a[r];
            wready  = wr_a[r];
            bvalid  = bv_a[r];
            bresp   = h_resp[(hidx < n) ? hidx : 0];
            if (e_busy[r] || hidx >= n) begin
                waddr_i = $urandom;
                wdata_i = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                waddr_i = h_addr[hidx];
                wdata_i = h_data[hidx];
            end
            @(negedge clk);
            chk("busy", busy_o, e_busy[r]);
            chk("awvalid", awvalid, e_awv[r]);
            chk("wvalid", wvalid, e_wv[r]);
            chk("bready", bready, e_br[r]);
            chk("done", done_o, e_dn[r]);
            if (e_awv[r]) chk("awaddr", awaddr, e_awaddr[r]);
            if (e_wv[r]) begin
                chk("wdata", wdata, e_wd[r]);
                chk("wlast", wlast, e_wl[r]);
                chk("wstrb", wstrb, 4'hF);
            end
            if (awvalid && awready) begin
                if (got_aw < 8) aw_cyc[got_aw] = r;
                got_aw++;
            end
            if (wvalid && wready) got_w++;
            if (done_o) begin
                hidx++;
                done_cyc = r;
            end
        end
        wen_i = 0;
        got_dn = hidx;
        chk("aw_count", got_aw, n);
        chk("w_count", got_w, 4 * n);
        chk("done_count", got_dn, n);
    endtask

    task automatic all_ready();
        for (int r = 0; r < AL; r++) begin
            awr_a[r] = 1; wr_a[r] = 1; bv_a[r] = 1;
        end
        for (int i = 0; i < 8; i++) h_resp[i] = AXI_RESP_OKAY;
    endtask

    localparam logic [127:0] LINE1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [31:0]  ADDR1 = 32'h1000_0014;
    localparam logic [31:0]  AL1   = 32'h1000_0010;

    initial begin
        rst = 1; wen_i = 0; waddr_i = 0; wdata_i = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;

        tbl[0] = '{1, 1, ADDR1, LINE1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0};
        tbl[1] = '{0, 1, ADDR1, LINE1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 4'h0};
        tbl[2] = '{0, 0, 32'h0, '0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 0, AL1, 32'h0, 4'h0};
        tbl[3] = '{0, 0, 32'h0, '0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, AL1, 32'h1111_1111, 4'hF};
        tbl[4] = '{0, 0, 32'h0, '0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, AL1, 32'h2222_2222, 4'hF};
        tbl[5] = '{0, 0, 32'h0, '0, 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, AL1, 32'h3333_3333, 4'hF};
        tbl[6] = '{0, 0, 32'h0, '0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 0, AL1, 32'h4444_4444, 4'hF};
        tbl[7] = '{0, 0, 32'h0, '0, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, AL1, 32'h0, 4'h0};
        tbl[8] = '{0, 0, 32'h0, '0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 0, AL1, 32'h0, 4'h0};
        tbl[9] = '{0, 0, 32'h0, '0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, AL1, 32'h0, 4'h0};

        repeat (2) @(posedge clk);

        // Single line with all readys high; row 0 also checks reset beats wen_i
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            rst     = tbl[i].rst;
            wen_i   = tbl[i].wen;
            waddr_i = tbl[i].addr;
            wdata_i = tbl[i].data;
            awready = tbl[i].awr;
            wready  = tbl[i].wr;
            bvalid  = tbl[i].bv;
            @(negedge clk);
            chk("t_awvalid", awvalid, tbl[i].awv);
            chk("t_wvalid", wvalid, tbl[i].wv);
            chk("t_wlast", wlast, tbl[i].wl);
            chk("t_bready", bready, tbl[i].br);
            chk("t_done", done_o, tbl[i].dn);
            chk("t_busy", busy_o, tbl[i].busy);
            if (tbl[i].pay || tbl[i].awv) chk("t_awaddr", awaddr, tbl[i].awaddr);
            if (tbl[i].pay || tbl[i].wv) begin
                chk("t_wdata", wdata, tbl[i].wdat);
                chk("t_wstrb", wstrb, tbl[i].wstrb);
            end
`ifdef WB_AXI_DRAIN_ERR_EN
            if (tbl[i].rst) begin
                chk("t_err_rst", err_o, 1'b0);
                chk("t_erraddr_rst", err_addr_o, 32'h0);
            end
`endif
        end
        chk("awid", awid, 4'd1);
        chk("awlen", awlen, 8'd3);
        chk("awsize", awsize, 3'b010);
        chk("awburst", awburst, 2'b01);

        // Back-to-back heads with wen_i held high
        all_ready();
        h_addr[0] = 32'h0000_A008; h_data[0] = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        h_addr[1] = 32'h0000_B00C; h_data[1] = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        run(2);
        chk("b2b_aw1_cycle", aw_cyc[0], 1);
        chk("b2b_aw2_cycle", aw_cyc[1], 9);

        // Backpressure: awready low 3 cycles, wready alternating
        all_ready();
        for (int r = 1; r <= 3; r++) awr_a[r] = 0;
        for (int r = 0; r < CAP; r++) wr_a[r] = r[0];
        h_addr[0] = 32'h0000_C000;
        h_data[0] = {32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001, 32'hC0C0_0000};
        run(1);

        // Late B: wlast at relative cycle 5, bvalid 10 cycles later
        all_ready();
        for (int r = 0; r < 15; r++) bv_a[r] = 0;
        h_addr[0] = 32'h0000_D010;
        h_data[0] = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        run(1);
        chk("lateb_done_cycle", done_cyc, 16);

        // Reset after the second beat, together with wen_i
        @(posedge clk); #1;
        wen_i = 1; waddr_i = 32'h0000_E000; wdata_i = {4{32'hEEEE_EEEE}};
        awready = 1; wready = 1; bvalid = 0;
        @(posedge clk); #1; wen_i = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1; rst = 1; wen_i = 1;
        @(posedge clk); #1; rst = 0; wen_i = 0;
        @(negedge clk);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        all_ready();
        h_addr[0] = 32'h0000_F004;
        h_data[0] = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
        run(1);

        // Randomized readys and heads
        for (int it = 0; it < 4; it++) begin
            all_ready();
            for (int r = 0; r < 300; r++) begin
                awr_a[r] = ($urandom_range(0, 9) < 7);
                wr_a[r]  = ($urandom_range(0, 9) < 7);
                bv_a[r]  = ($urandom_range(0, 9) < 6);
            end
            for (int i = 0; i < 4; i++) begin
                h_addr[i] = $urandom;
                h_data[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            run(4);
        end

        // SLVERR on the 0x2000 burst, then OKAY; entries still retire
        all_ready();
        h_addr[0] = 32'h0000_2000; h_data[0] = {32'h23, 32'h22, 32'h21, 32'h20};
        h_resp[0] = 2'b10;
        h_addr[1] = 32'h0000_3000; h_data[1] = {32'h33, 32'h32, 32'h31, 32'h30};
        run(2);
`ifdef WB_AXI_DRAIN_ERR_EN
        chk("err_sticky", err_o, 1'b1);
        chk("err_addr", err_addr_o, 32'h0000_2000);
        @(negedge clk);
        chk("err_hold", err_o, 1'b1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
